// File: rtl/tone_mixer_pkg.sv
// rtl/tone_mixer_pkg.sv - shared constants and helpers for the tone voice mixer
// Contents: mix-mode encodings, reset half-period, effective half-period function.
package tone_mixer_pkg;

  localparam logic MIX_OR = 1'b0;
  localparam logic MIX_SD = 1'b1;

  localparam int DEFAULT_HP = 10;

  // A half-period of zero would never wrap; treat it as one so the voice
  // toggles every cycle instead.
  function automatic logic [31:0] eff_hp(input logic [31:0] hp);
    return (hp == 32'd0) ? 32'd1 : hp;
  endfunction

endpackage

// File: rtl/tone_voice.sv
// rtl/tone_voice.sv - one square-wave voice with programmable half-period
// Ports:
//   CLK, RST_N  clock, asynchronous active-low reset
//   KEY         gate; 0 silences and phase-resets the voice
//   WE, DATA    half-period load strobe and value
//   OUT         registered square wave
module tone_voice
  import tone_mixer_pkg::*;
#(
  parameter int DIV_W    = 24,
  parameter int RESET_HP = DEFAULT_HP
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             KEY,
  input  logic             WE,
  input  logic [DIV_W-1:0] DATA,
  output logic             OUT
);

  logic [DIV_W-1:0] hp;
  logic [DIV_W-1:0] cnt;
  logic [31:0]      heff;
  logic             wrap;

  // ">=" rather than "==" so a half-period shrunk below the running count
  // still wraps on the next edge instead of running to the counter limit.
  always_comb begin
    heff = eff_hp(32'(hp));
    wrap = (32'(cnt) >= (heff - 32'd1));
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hp  <= DIV_W'(RESET_HP);
      cnt <= '0;
      OUT <= 1'b0;
    end else begin
      if (WE) begin
        hp <= DATA;
      end
      if (KEY) begin
        if (wrap) begin
          cnt <= '0;
          OUT <= ~OUT;
        end else begin
          cnt <= cnt + DIV_W'(1);
        end
      end else begin
        cnt <= '0;
        OUT <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tone_voice_mixer.sv
// rtl/tone_voice_mixer.sv - polyphonic square-wave generator with OR / sigma-delta mix
// Ports:
//   CLK, RST_N           clock, asynchronous active-low reset
//   KEY                  per-voice gates
//   CFG_WE/ADDR/DATA     half-period write port (out-of-range ADDR ignored)
//   MIX_MODE             0 = OR mix, 1 = first-order sigma-delta mix
//   AUDIO                registered mixed audio bit
//   VOICE_OUT            registered per-voice square waves
//   ACTIVE_CNT           registered number of KEY bits set
module tone_voice_mixer #(
  parameter int  NUM_VOICES = 4,
  parameter int  DIV_W      = 24,
  parameter int  DEFAULT_HP = tone_mixer_pkg::DEFAULT_HP,
  localparam int VA_W       = $clog2(NUM_VOICES),
  localparam int SUM_W      = $clog2(NUM_VOICES + 1)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [NUM_VOICES-1:0] KEY,
  input  logic                  CFG_WE,
  input  logic [VA_W-1:0]       CFG_ADDR,
  input  logic [DIV_W-1:0]      CFG_DATA,
  input  logic                  MIX_MODE,
  output logic                  AUDIO,
  output logic [NUM_VOICES-1:0] VOICE_OUT,
  output logic [SUM_W-1:0]      ACTIVE_CNT
);

  import tone_mixer_pkg::*;

  logic [NUM_VOICES-1:0] voice_we;
  logic [NUM_VOICES-1:0] voice_sq;
  logic [SUM_W-1:0]      sum;
  logic [SUM_W-1:0]      key_cnt;
  logic [SUM_W-1:0]      acc;
  logic [SUM_W-1:0]      acc_next;
  logic [SUM_W:0]        tmp;
  logic                  sd_bit;

  always_comb begin
    voice_we = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (CFG_WE && (int'(CFG_ADDR) == v)) begin
        voice_we[v] = 1'b1;
      end
    end
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    tone_voice #(
      .DIV_W    (DIV_W),
      .RESET_HP (DEFAULT_HP)
    ) u_voice (
      .CLK   (CLK),
      .RST_N (RST_N),
      .KEY   (KEY[v]),
      .WE    (voice_we[v]),
      .DATA  (CFG_DATA),
      .OUT   (voice_sq[v])
    );
  end

  always_comb begin
    sum     = '0;
    key_cnt = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      sum     = sum + SUM_W'(voice_sq[v]);
      key_cnt = key_cnt + SUM_W'(KEY[v]);
    end
  end

  // acc stays in [0, NUM_VOICES-1] and sum <= NUM_VOICES, so one extra bit
  // holds tmp and a single subtraction brings it back into range.
  always_comb begin
    tmp = {1'b0, acc} + (SUM_W + 1)'(sum);
    if (tmp >= (SUM_W + 1)'(NUM_VOICES)) begin
      sd_bit   = 1'b1;
      acc_next = SUM_W'(tmp - (SUM_W + 1)'(NUM_VOICES));
    end else begin
      sd_bit   = 1'b0;
      acc_next = SUM_W'(tmp);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      AUDIO      <= 1'b0;
      ACTIVE_CNT <= '0;
      acc        <= '0;
    end else begin
      ACTIVE_CNT <= key_cnt;
      if (MIX_MODE == MIX_SD) begin
        AUDIO <= sd_bit;
        acc   <= acc_next;
      end else begin
        // Holding acc at 0 makes every entry into sigma-delta mode start clean.
        AUDIO <= |voice_sq;
        acc   <= '0;
      end
    end
  end

  assign VOICE_OUT = voice_sq;

endmodule

// File: tb/tb_tone_voice_mixer.sv
// tb/tb_tone_voice_mixer.sv - directed vector bench for tone_voice_mixer
module tb_tone_voice_mixer;

  logic       CLK;
  logic       RST_N;
  logic [3:0] KEY;
  logic       CFG_WE;
  logic [1:0] CFG_ADDR;
  logic [7:0] CFG_DATA;
  logic       MIX_MODE;
  logic       AUDIO;
  logic [3:0] VOICE_OUT;
  logic [2:0] ACTIVE_CNT;

  logic [2:0] KEY3;
  logic       CFG_WE3;
  logic [1:0] CFG_ADDR3;
  logic [7:0] CFG_DATA3;
  logic       MIX_MODE3;
  logic       AUDIO3;
  logic [2:0] VOICE_OUT3;
  logic [1:0] ACTIVE_CNT3;

  int n_vec = 0;
  int n_err = 0;

  tone_voice_mixer #(.NUM_VOICES(4), .DIV_W(8)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .KEY        (KEY),
    .CFG_WE     (CFG_WE),
    .CFG_ADDR   (CFG_ADDR),
    .CFG_DATA   (CFG_DATA),
    .MIX_MODE   (MIX_MODE),
    .AUDIO      (AUDIO),
    .VOICE_OUT  (VOICE_OUT),
    .ACTIVE_CNT (ACTIVE_CNT)
  );

  tone_voice_mixer #(.NUM_VOICES(3), .DIV_W(8)) dut3 (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .KEY        (KEY3),
    .CFG_WE     (CFG_WE3),
    .CFG_ADDR   (CFG_ADDR3),
    .CFG_DATA   (CFG_DATA3),
    .MIX_MODE   (MIX_MODE3),
    .AUDIO      (AUDIO3),
    .VOICE_OUT  (VOICE_OUT3),
    .ACTIVE_CNT (ACTIVE_CNT3)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [3:0] key;
    logic       we;
    logic [1:0] addr;
    logic [7:0] data;
    logic       mode;
    logic [3:0] vo;
    logic       audio;
    logic [2:0] act;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    CFG_WE   = 1'b1;
    CFG_ADDR = a;
    CFG_DATA = d;
    step(1);
    CFG_WE   = 1'b0;
  endtask

  logic exp_bit;
  logic [4:0] pat;

  initial begin
    RST_N = 1'b0; KEY = '0; CFG_WE = 1'b0; CFG_ADDR = '0; CFG_DATA = '0; MIX_MODE = 1'b0;
    KEY3 = '0; CFG_WE3 = 1'b0; CFG_ADDR3 = '0; CFG_DATA3 = '0; MIX_MODE3 = 1'b0;

    //             key     we    addr  data   mode  vo      au    act
    tbl.push_back('{4'h0, 1'b1, 2'd0, 8'd3, 1'b0, 4'h0, 1'b0, 3'd0});
    tbl.push_back('{4'h1, 1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 1'b0, 3'd1});
    tbl.push_back('{4'h1, 1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 1'b0, 3'd1});
    tbl.push_back('{4'h1, 1'b0, 2'd0, 8'd0, 1'b0, 4'h1, 1'b0, 3'd1});
    tbl.push_back('{4'h1, 1'b0, 2'd0, 8'd0, 1'b0, 4'h1, 1'b1, 3'd1});
    tbl.push_back('{4'h1, 1'b0, 2'd0, 8'd0, 1'b0, 4'h1, 1'b1, 3'd1});
    tbl.push_back('{4'h1, 1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 1'b1, 3'd1});
    tbl.push_back('{4'h1, 1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 1'b0, 3'd1});
    tbl.push_back('{4'h1, 1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 1'b0, 3'd1});
    tbl.push_back('{4'h1, 1'b0, 2'd0, 8'd0, 1'b0, 4'h1, 1'b0, 3'd1});
    tbl.push_back('{4'h1, 1'b0, 2'd0, 8'd0, 1'b0, 4'h1, 1'b1, 3'd1});
    tbl.push_back('{4'h0, 1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 1'b1, 3'd0});
    tbl.push_back('{4'h0, 1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 1'b0, 3'd0});
    tbl.push_back('{4'h0, 1'b1, 2'd1, 8'd0, 1'b0, 4'h0, 1'b0, 3'd0});
    tbl.push_back('{4'h2, 1'b0, 2'd0, 8'd0, 1'b0, 4'h2, 1'b0, 3'd1});
    tbl.push_back('{4'h2, 1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 1'b1, 3'd1});
    tbl.push_back('{4'h2, 1'b0, 2'd0, 8'd0, 1'b0, 4'h2, 1'b0, 3'd1});
    tbl.push_back('{4'h0, 1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 1'b1, 3'd0});
    tbl.push_back('{4'h0, 1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 1'b0, 3'd0});

    // Reset state
    #12;
    chk("rst_audio", 32'(AUDIO), 32'd0);
    chk("rst_vo", 32'(VOICE_OUT), 32'd0);
    chk("rst_act", 32'(ACTIVE_CNT), 32'd0);
    RST_N = 1'b1;

    // Three-voice instance: CFG_ADDR=3 is out of range, voices keep HP=10
    KEY3 = 3'b111; CFG_WE3 = 1'b1; CFG_ADDR3 = 2'd3; CFG_DATA3 = 8'd1;
    step(1);
    CFG_WE3 = 1'b0;
    step(8);
    chk("nv3_vo_e9", 32'(VOICE_OUT3), 32'd0);
    chk("nv3_act", 32'(ACTIVE_CNT3), 32'd3);
    step(1);
    chk("nv3_vo_e10", 32'(VOICE_OUT3), 32'h7);
    KEY3 = '0;
    step(1);

    // Table: HP[0]=3 timing and OR mix, then HP[1]=0 toggling every edge
    for (int i = 0; i < tbl.size(); i++) begin
      KEY = tbl[i].key; CFG_WE = tbl[i].we; CFG_ADDR = tbl[i].addr;
      CFG_DATA = tbl[i].data; MIX_MODE = tbl[i].mode;
      step(1);
      chk($sformatf("vec%0d_vo", i), 32'(VOICE_OUT), 32'(tbl[i].vo));
      chk($sformatf("vec%0d_audio", i), 32'(AUDIO), 32'(tbl[i].audio));
      chk($sformatf("vec%0d_act", i), 32'(ACTIVE_CNT), 32'(tbl[i].act));
    end
    CFG_WE = 1'b0;

    // HP shrink below running count
    wr(2'd2, 8'd255);
    KEY = 4'b0100;
    step(100);
    chk("shrink_pre", 32'(VOICE_OUT[2]), 32'd0);
    wr(2'd2, 8'd4);
    chk("shrink_old_hp", 32'(VOICE_OUT[2]), 32'd0);
    step(1);
    chk("shrink_wrap", 32'(VOICE_OUT[2]), 32'd1);
    for (int i = 0; i < 8; i++) begin
      step(1);
      exp_bit = (i < 3 || i == 7) ? 1'b1 : 1'b0;
      chk($sformatf("shrink_p8_%0d", i), 32'(VOICE_OUT[2]), 32'(exp_bit));
    end
    KEY = '0;
    step(2);

    // Sigma-delta mix, all HP = 5
    for (int v = 0; v < 4; v++) wr(2'(v), 8'd5);
    MIX_MODE = 1'b1; KEY = 4'b1111;
    step(5);
    chk("sd4_vo", 32'(VOICE_OUT), 32'hf);
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk($sformatf("sd4_audio%0d", i), 32'(AUDIO), 32'd1);
    end
    KEY = '0; MIX_MODE = 1'b0;
    step(2);

    MIX_MODE = 1'b1; KEY = 4'b0011;
    step(5);
    chk("sd2_vo", 32'(VOICE_OUT), 32'h3);
    pat = 5'b01010;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk($sformatf("sd2_audio%0d", i), 32'(AUDIO), 32'(pat[4-i]));
    end
    KEY = '0; MIX_MODE = 1'b0;
    step(2);

    MIX_MODE = 1'b1; KEY = 4'b0001;
    step(5);
    pat = 5'b00010;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk($sformatf("sd1_audio%0d", i), 32'(AUDIO), 32'(pat[4-i]));
    end
    KEY = '0; MIX_MODE = 1'b0;
    step(2);

    // Write and key release on voice 3 in the same cycle
    KEY = 4'b1000;
    step(6);
    chk("wrrel_high", 32'(VOICE_OUT[3]), 32'd1);
    KEY = 4'b0000;
    wr(2'd3, 8'd2);
    chk("wrrel_off", 32'(VOICE_OUT[3]), 32'd0);
    KEY = 4'b1000;
    step(1);
    chk("wrrel_e1", 32'(VOICE_OUT[3]), 32'd0);
    step(1);
    chk("wrrel_e2", 32'(VOICE_OUT[3]), 32'd1);
    step(2);
    chk("wrrel_e4", 32'(VOICE_OUT[3]), 32'd0);

    // Reset mid-note in sigma-delta mode
    MIX_MODE = 1'b1; KEY = 4'b1111;
    step(6);
    chk("mid_vo_before", 32'(VOICE_OUT), 32'hf);
    RST_N = 1'b0;
    #1;
    chk("mid_rst_audio", 32'(AUDIO), 32'd0);
    chk("mid_rst_vo", 32'(VOICE_OUT), 32'd0);
    chk("mid_rst_act", 32'(ACTIVE_CNT), 32'd0);
    KEY = 4'b0001; MIX_MODE = 1'b0;
    RST_N = 1'b1;
    step(1);
    chk("post_rst_act", 32'(ACTIVE_CNT), 32'd1);
    step(8);
    chk("post_rst_e9", 32'(VOICE_OUT), 32'd0);
    step(1);
    chk("post_rst_e10", 32'(VOICE_OUT), 32'd1);
    step(9);
    chk("post_rst_e19", 32'(VOICE_OUT), 32'd1);
    step(1);
    chk("post_rst_e20", 32'(VOICE_OUT), 32'd0);

    // Mode 1 -> 0 -> 1 with KEY=0001 held (HP[0]=10)
    KEY = '0;
    step(1);
    MIX_MODE = 1'b1; KEY = 4'b0001;
    step(10);
    chk("mode_vo_high", 32'(VOICE_OUT), 32'd1);
    pat = 5'b00010;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk($sformatf("mode_sd_a%0d", i), 32'(AUDIO), 32'(pat[4-i]));
    end
    MIX_MODE = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(1);
      chk($sformatf("mode_or_a%0d", i), 32'(AUDIO), 32'd1);
    end
    MIX_MODE = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk($sformatf("mode_re_a%0d", i), 32'(AUDIO), 32'(pat[4-i]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tone_voice_mixer.md
Name: tone_voice_mixer

Overview:
Parametrised polyphonic square-wave tone generator for the FPGA wavetable synth audio path. It has NUM_VOICES independent voices, each with a run-time programmable half-period divisor and its own key gate. Voices are mixed onto a single 1-bit AUDIO pin, either as a logical OR or through a first-order sigma-delta modulator whose pulse density is proportional to the number of voices currently high. It replaces the fixed-divisor, OR-only tone logic and sits between the key inputs and the audio output pin.

Parameters:
NUM_VOICES, 4, number of independent voices (>=2)
DIV_W, 24, width of each half-period register and voice counter
DEFAULT_HP, 10, half-period value every voice holds after reset
VA_W, $clog2(NUM_VOICES), width of CFG_ADDR (derived, not overridden)
SUM_W, $clog2(NUM_VOICES+1), width of voice sum and ACTIVE_CNT (derived)

Ports:
CLK  in  1  system clock; all state updates on rising edge
RST_N  in  1  asynchronous active-low reset
KEY  in  NUM_VOICES  per-voice gate; 1 = voice sounding
CFG_WE  in  1  half-period write strobe, one cycle per write
CFG_ADDR  in  VA_W  voice index for write
CFG_DATA  in  DIV_W  new half-period value
MIX_MODE  in  1  0 = OR mix, 1 = sigma-delta mix
AUDIO  out  1  registered mixed audio bit
VOICE_OUT  out  NUM_VOICES  registered per-voice square waves
ACTIVE_CNT  out  SUM_W  registered count of KEY bits set

Behaviour:
- Reset (RST_N low, asynchronous): all voice counters 0; VOICE_OUT 0; AUDIO 0; ACTIVE_CNT 0; sigma-delta accumulator 0; every HP[v] = DEFAULT_HP.
- Effective half-period heff = max(HP[v], 1). HP = 0 is treated as 1, so the voice toggles every cycle.
- Voice v with KEY[v]=1, each edge:
  - if cnt >= heff-1: cnt <= 0 and VOICE_OUT[v] toggles;
  - otherwise cnt <= cnt+1.
  - The ">=" comparison guarantees a wrap on the next edge when HP shrinks below the current cnt. Output period = 2*heff cycles.
- Voice v with KEY[v]=0: cnt <= 0 and VOICE_OUT[v] <= 0 on the next edge. A note-off therefore silences and phase-resets the voice.
- Config write:
  - CFG_WE=1 loads HP[CFG_ADDR] <= CFG_DATA at the edge. The compare in that same cycle uses the old HP; the new value applies from the next cycle.
  - CFG_ADDR >= NUM_VOICES: write ignored.
  - A write never resets cnt or VOICE_OUT.
- sum = popcount(VOICE_OUT), combinational from registered outputs, width SUM_W.
- MIX_MODE=0: AUDIO <= |VOICE_OUT; accumulator held at 0.
- MIX_MODE=1, with acc in [0, NUM_VOICES-1] and tmp = acc + sum:
  - if tmp >= NUM_VOICES: AUDIO <= 1, acc <= tmp - NUM_VOICES;
  - else AUDIO <= 0, acc <= tmp.
  - Long-run density of AUDIO = sum/NUM_VOICES. sum = NUM_VOICES gives constant 1; sum = 0 gives constant 0 once acc drains.
- Mode switch: acc is 0 while MIX_MODE=0, so every entry into mode 1 starts from acc = 0.
- Latency: KEY/HP to VOICE_OUT as defined above. VOICE_OUT change to AUDIO is 1 cycle. KEY to ACTIVE_CNT is 1 cycle.
- Simultaneous write and key release on the same voice: both take effect (HP updated, voice reset).
- Reset mid-note: all outputs drop immediately; voices restart from cnt = 0 on the first edge after release if KEY is held.

Decomposition:
- Package tone_mixer_pkg:
  - MIX_OR / MIX_SD mode constants;
  - DEFAULT_HP default;
  - a function computing the effective half-period (0 maps to 1).
- Sub-module tone_voice: holds one counter, one half-period register and one square output. Ports: CLK, RST_N, KEY, WE, DATA, OUT. Instantiated NUM_VOICES times by generate.
- The top level holds the address decode, popcount, sigma-delta accumulator and output registers.

Test Plan:
- NUM_VOICES=4, DIV_W=8. Reset, write HP[0]=3, KEY=0001, MIX_MODE=0 -> VOICE_OUT[0] first rises on the 3rd edge after KEY, then has period 6 (3 high/3 low); AUDIO equals VOICE_OUT[0] delayed 1 cycle; ACTIVE_CNT=1.
- HP[1]=0, KEY=0010 -> VOICE_OUT[1] toggles every edge. Write HP[2]=255, KEY=0100, run to cnt≈100, write HP[2]=4 -> wrap/toggle on the next edge, then period 8.
- MIX_MODE=1, HP all 5, KEY=1111 simultaneously -> during high phase AUDIO constant 1. KEY=0011 -> during high phase AUDIO alternates 0,1,0,1 (density 1/2). KEY=0001 -> one 1 per 4 cycles.
- Write with CFG_ADDR=3 and KEY[3] released in the same cycle -> VOICE_OUT[3]=0 next edge; a later key-on uses the new HP. With NUM_VOICES=3 and CFG_ADDR=3 -> no HP changes.
- Assert RST_N low mid-note in mode 1 -> AUDIO, VOICE_OUT, ACTIVE_CNT go 0 without a clock edge; after release, HP values are back to DEFAULT_HP (period 20).
- Toggle MIX_MODE 1->0->1 with KEY=0001 held -> in mode 0 AUDIO tracks the OR; on re-entry the first 1 appears on the 4th edge of the high phase (acc restarted at 0).
